fifo_wr_arbiter: RTL and testbench

// - Round-robin arbiter sharing the write port of the dual-clock byte FIFO among NUM_REQ producers.
// - Sits entirely in the write-clock domain, directly in front of the FIFO's wr_en/data_in/full interface.
// - Bounds each grant to BURST_MAX words so no producer starves the others; honours FIFO full word by word.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter in front of the FIFO write port (write-clock domain only).
// Each grant is limited to BURST_MAX accepted words. FIFO full stalls a grant
// word by word but does not end it.
// Optional feature: define ARB_STATS_EN to add the 16-bit saturating stall_cnt output.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                      clk_wr,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int unsigned     OwnW      = $clog2(NUM_REQ);
  localparam logic [7:0]      BurstLast = 8'(BURST_MAX - 1);
  localparam logic [OwnW-1:0] LastReq   = OwnW'(NUM_REQ - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [OwnW-1:0]   owner_q;
  logic [OwnW-1:0]   last_owner_q;
  logic [7:0]        burst_cnt_q;

  logic              pick_valid;
  logic [OwnW-1:0]   pick;
  logic [OwnW-1:0]   cand;
  logic              owner_req;
  logic [DATA_W-1:0] owner_data;
  logic              in_grant;
  logic              accept;

  // Round-robin pick: first set req scanning from last_owner+1, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = OwnW'((32'(last_owner_q) + k) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Select the current owner's request and data slice.
  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OwnW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write-port outputs; gated by rst_n so a reset edge never commits a partial word.
  always_comb begin
    in_grant   = (state_q == StGrant) && rst_n;
    accept     = in_grant && owner_req && !fifo_full;
    gnt        = '0;
    if (in_grant && !fifo_full) begin
      gnt[owner_q] = 1'b1;
    end
    fifo_wr_en = accept;
    fifo_data  = in_grant ? owner_data : '0;
  end

  // Arbitration FSM: one IDLE cycle per arbitration, grant ends on burst limit or withdrawn req.
  always_ff @(posedge clk_wr) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= LastReq;
      burst_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q     <= StGrant;
            owner_q     <= pick;
            burst_cnt_q <= '0;
          end
        end
        StGrant: begin
          if (!owner_req) begin
            state_q      <= StIdle;
            last_owner_q <= owner_q;
          end else if (!fifo_full) begin
            if (burst_cnt_q == BurstLast) begin
              state_q      <= StIdle;
              last_owner_q <= owner_q;
              burst_cnt_q  <= '0;
            end else begin
              burst_cnt_q <= burst_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Count cycles where the owner has a word ready but the FIFO is full; saturating.
  always_ff @(posedge clk_wr) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state_q == StGrant) && owner_req && fifo_full && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter (4 requesters, 8-bit data, bursts of 4).
// Producers are modelled as word quotas; requester i sends 8'h11*(n+1) for its n-th word.
module tb_fifo_wr_arbiter;

  logic        clk_wr;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (8),
    .BURST_MAX(4)
  ) dut (
    .clk_wr    (clk_wr),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data (fifo_data)
`ifdef ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   wr_count = 0;
  int   quota[4];
  int   cnt[4];
  int   wr_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int src, input int n);
    exp_t e;
    e.src  = src;
    e.data = 8'(17 * n);
    exp_q.push_back(e);
  endtask

  task automatic update_req();
    for (int i = 0; i < 4; i++) begin
      req[i]             = (quota[i] != 0);
      req_data[i*8 +: 8] = 8'(17 * (cnt[i] + 1));
    end
  endtask

  task automatic clear_producers();
    for (int i = 0; i < 4; i++) begin
      quota[i] = 0;
      cnt[i]   = 0;
    end
  endtask

  // One clock: note accepted words mid-cycle, advance producers just after the edge.
  task automatic cycle();
    logic [3:0] acc;
    @(negedge clk_wr);
    acc = req & gnt;
    @(posedge clk_wr);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        cnt[i]++;
        quota[i]--;
      end
    end
    update_req();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Monitor: every FIFO write is popped against the scoreboard.
  always @(negedge clk_wr) begin
    exp_t e;
    if (fifo_wr_en === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got gnt=%b data=%h expected no write", gnt, fifo_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_gnt", 32'(gnt), 32'(4'b0001 << e.src));
        check("wr_data", 32'(fifo_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset with all four requesting; requester 0 has two bursts queued.
    rst_n     = 1'b0;
    fifo_full = 1'b0;
    clear_producers();
    quota[0] = 8; quota[1] = 4; quota[2] = 4; quota[3] = 4;
    update_req();
    for (int r = 0; r < 2; r++) begin
      @(posedge clk_wr);
      @(negedge clk_wr);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    end
    @(posedge clk_wr);
    #1;
    rst_n = 1'b1;

    // Round-robin 0,1,2,3,0 with 4 words each.
    for (int n = 1; n <= 4; n++) push(0, n);
    for (int n = 1; n <= 4; n++) push(1, n);
    for (int n = 1; n <= 4; n++) push(2, n);
    for (int n = 1; n <= 4; n++) push(3, n);
    for (int n = 5; n <= 8; n++) push(0, n);
    wr_base = wr_count;
    run(5);
    check("rr_first_burst", 32'(wr_count - wr_base), 32'd4);
    run(20);
    check("rr_all_writes", 32'(wr_count - wr_base), 32'd20);
    check("rr_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single requester 2: 4 writes, one idle cycle, 4 more.
    clear_producers();
    quota[2] = 8;
    update_req();
    for (int n = 1; n <= 8; n++) push(2, n);
    wr_base = wr_count;
    run(5);
    check("single_burst1", 32'(wr_count - wr_base), 32'd4);
    run(1);
    check("single_idle", 32'(wr_count - wr_base), 32'd4);
    run(4);
    check("single_burst2", 32'(wr_count - wr_base), 32'd8);
    run(2);
    check("single_quiet", 32'(wr_count - wr_base), 32'd8);
    check("single_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure on owner 1 after 2 words; burst count must be held across full.
    clear_producers();
    quota[1] = 6;
    update_req();
    for (int n = 1; n <= 6; n++) push(1, n);
    wr_base = wr_count;
    run(3);
    check("bp_before_full", 32'(wr_count - wr_base), 32'd2);
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_wr);
      check("bp_full_gnt", 32'(gnt), 32'h0);
      check("bp_full_wr_en", 32'(fifo_wr_en), 32'h0);
      @(posedge clk_wr);
      #1;
    end
    fifo_full = 1'b0;
    run(3);
    check("bp_resume", 32'(wr_count - wr_base), 32'd4);
    run(3);
    check("bp_regrant", 32'(wr_count - wr_base), 32'd6);
    run(1);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef ARB_STATS_EN
    check("bp_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // Early release: owner 2 leaves after 1 word, requester 3 is next.
    clear_producers();
    quota[2] = 1;
    quota[3] = 2;
    update_req();
    push(2, 1);
    push(3, 1);
    push(3, 2);
    wr_base = wr_count;
    run(3);
    check("early_one_word", 32'(wr_count - wr_base), 32'd1);
    run(1);
    check("early_idle", 32'(wr_count - wr_base), 32'd1);
    run(2);
    check("early_next_owner", 32'(wr_count - wr_base), 32'd3);
    run(1);
    check("early_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while owner 3 is mid-burst: nothing written, next grant goes to 0.
    clear_producers();
    quota[3] = 4;
    update_req();
    push(3, 1);
    push(3, 2);
    for (int n = 1; n <= 4; n++) push(0, n);
    push(3, 3);
    push(3, 4);
    wr_base = wr_count;
    run(3);
    check("rstmid_before", 32'(wr_count - wr_base), 32'd2);
    quota[0] = 4;
    rst_n    = 1'b0;
    update_req();
    @(negedge clk_wr);
    check("rstmid_gnt", 32'(gnt), 32'h0);
    check("rstmid_wr_en", 32'(fifo_wr_en), 32'h0);
    @(posedge clk_wr);
    #1;
    rst_n = 1'b1;
`ifdef ARB_STATS_EN
    check("rstmid_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    run(9);
    check("rstmid_after", 32'(wr_count - wr_base), 32'd8);
    check("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
